servfarm_apb_master: RTL
========================

// Module: servfarm_apb_master
// PURPOSE
// - APB3 master that turns single host commands (valid/ready) into one APB transfer each.
// - Sits directly upstream of the servfarm CSR/farm-select decoder and drives its
//   paddr/psel/penable/pwrite/pwdata; returns prdata/perr to the host as a response beat.
// - One outstanding transfer; no pipelining across commands.
// PARAMETERS
// - ADDR_W          32   width of cmd_addr / paddr
// - DATA_W          32   width of wdata/rdata buses
// - TIMEOUT_CYCLES  256  ACCESS cycles without pready before abort (SERVFARM_APB_TIMEOUT_EN only); >=2
// PORTS
// - clk        in   1       clock, all logic on rising edge
// - rst_n      in   1       synchronous, active-low reset
// - cmd_valid  in   1       host command present
// - cmd_ready  out  1       block accepts command (=1 only in IDLE)
// - cmd_write  in   1       1=write, 0=read
// - cmd_addr   in   ADDR_W  target address
// - cmd_wdata  in   DATA_W  write data (ignored for reads)
// - rsp_valid  out  1       response beat present
// - rsp_ready  in   1       host consumes response
// - rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
// - rsp_err    out  1       slave perr or timeout
// - paddr      out  ADDR_W  APB address
// - psel       out  1       APB select
// - penable    out  1       APB enable
// - pwrite     out  1       APB direction
// - pwdata     out  DATA_W  APB write data
// - prdata     in   DATA_W  APB read data
// - pready     in   1       APB ready
// - perr       in   1       APB slave error (sampled only with pready)
// - busy       out  1       1 in any state but IDLE
// BEHAVIOUR
// - Reset: state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err=0; paddr, pwdata, rsp_rdata=0.
// - Reset mid-transfer aborts at that edge: psel/penable low next cycle, no response issued.
// - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; all outputs registered except cmd_ready, busy.
// - IDLE: cmd_ready=1. On cmd_valid: latch addr/wdata/write into paddr/pwdata/pwrite, psel<=1,
//   penable<=0, -> SETUP.
// - SETUP: exactly one cycle; penable<=1 -> ACCESS.
// - ACCESS: hold psel=penable=1, paddr/pwdata/pwrite stable. On pready: rsp_rdata<=pwrite?0:prdata,
//   rsp_err<=perr, psel<=0, penable<=0, rsp_valid<=1 -> RESP. No pready: stay (wait state).
// - RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready; on rsp_ready rsp_valid<=0,
//   rsp_err<=0 -> IDLE. cmd_valid ignored in RESP (cmd_ready=0).
// - paddr/pwdata/pwrite keep last value after transfer (no return to 0).
// - Min 4 cycles cmd accept -> next cmd accept (pready in first ACCESS cycle, rsp_ready held 1).
// CONFIGURATION
// - SERVFARM_APB_TIMEOUT_EN defined: counter cleared on SETUP->ACCESS, +1 per ACCESS cycle without
//   pready; when it reaches TIMEOUT_CYCLES (i.e. TIMEOUT_CYCLES ACCESS cycles elapsed, no pready)
//   drop psel/penable, rsp_rdata<=0, rsp_err<=1 -> RESP. pready in the final cycle wins (normal).
// - Not defined: no counter built; ACCESS waits indefinitely for pready. Ports identical.
// TESTING
// - Write 0x8000/0x00000003, pready 1st ACCESS -> psel 2 cycles, penable 2nd only, rsp err=0 rdata=0.
// - Read 0x8004, slave 2 wait states then prdata=0xFFFFFFFF -> paddr stable 4 cycles, rsp_rdata=0xFFFFFFFF.
// - Response with rsp_ready low 3 cycles, cmd_valid held high -> rsp stable, cmd_ready=0, no new psel.
// - Read with pready=1,perr=1,prdata=0x1234 -> rsp_err=1, rsp_rdata=0x1234; next cmd normal, err=0.
// - TIMEOUT_EN, TIMEOUT_CYCLES=8, pready never -> 8 ACCESS cycles then rsp_err=1, rdata=0; w/o macro
//   psel still 1 after 1000 cycles.
// - rst_n low in ACCESS -> psel/penable/rsp_valid 0 next edge, state IDLE, cmd_ready=1 after release.

Source files
------------

// File: rtl/servfarm_apb_master.sv
// servfarm_apb_master: APB3 master, one host command -> one APB transfer -> one response beat.
// FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE, one transfer outstanding at a time.
// Optional access timeout: define SERVFARM_APB_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES cycles without pready (response then carries err=1, rdata=0).
module servfarm_apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              perr,
  output logic              busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("servfarm_apb_master: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

`ifdef SERVFARM_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Access wait counter; only meaningful while in ACCESS
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef SERVFARM_APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef SERVFARM_APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          // pready beats a timeout landing in the same cycle
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = perr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef SERVFARM_APB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
